// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared encodings for the data-memory initiator
package mem_if_pkg;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] RESP      = 2'd3;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [3:0] SM_LB  = 4'b1001;
  localparam logic [3:0] SM_LH  = 4'b1011;
  localparam logic [3:0] SM_LW  = 4'b1111;
  localparam logic [3:0] SM_LBU = 4'b0001;
  localparam logic [3:0] SM_LHU = 4'b0011;
  localparam logic [3:0] SM_SB  = 4'b0001;
  localparam logic [3:0] SM_SH  = 4'b0011;
  localparam logic [3:0] SM_SW  = 4'b0111;
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
endpackage

// File: rtl/mem_req_decode.sv
// mem_req_decode: maps funct3/store/address to the memory sign_mask and error flags
module mem_req_decode
  import mem_if_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_store,
  input  logic [1:0] addr,
  output logic [3:0] sign_mask,
  output logic       illegal,
  output logic       misaligned
);
  // Translate the access type into the {sign, size mask} code and flag unsupported encodings
  always_comb begin
    sign_mask = 4'b0000;
    illegal   = 1'b0;
    if (is_store)
      case (funct3)
        SB:      sign_mask = SM_SB;
        SH:      sign_mask = SM_SH;
        SW:      sign_mask = SM_SW;
        default: illegal = 1'b1;
      endcase
    else
      case (funct3)
        LB:      sign_mask = SM_LB;
        LH:      sign_mask = SM_LH;
        LW:      sign_mask = SM_LW;
        LBU:     sign_mask = SM_LBU;
        LHU:     sign_mask = SM_LHU;
        default: illegal = 1'b1;
      endcase
  end
  assign misaligned = (funct3[1:0] == 2'b01) ? addr[0] : (funct3[1:0] == 2'b10) ? |addr : 1'b0;
endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: single-outstanding load/store initiator for the stalling data memory
module mem_initiator
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          is_load;
  logic [3:0]    dec_mask;
  logic          dec_ill;
  logic          dec_mis;
  logic          accept;
  logic          timeout;
  mem_req_decode u_dec (
    .funct3    (req_funct3),
    .is_store  (req_is_store),
    .addr      (req_addr[1:0]),
    .sign_mask (dec_mask),
    .illegal   (dec_ill),
    .misaligned(dec_mis)
  );
  // A busy memory cannot be reset, so a new request waits until it has drained
  assign req_ready = (state == IDLE) && !mem_clk_stall;
  assign accept    = req_valid && req_ready;
  assign timeout   = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
  // Handshake FSM: strobes drop as soon as the memory shows it latched the request, so they are low when it goes idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      is_load        <= 1'b0;
      mem_addr       <= 32'h0;
      mem_write_data <= 32'h0;
      mem_sign_mask  <= 4'h0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'h0;
      resp_err       <= ERR_OK;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (dec_ill || dec_mis) begin
            resp_err   <= dec_ill ? ERR_FUNCT3 : ERR_MISALIGN;
            resp_rdata <= 32'h0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            mem_addr       <= req_addr;
            mem_write_data <= req_wdata;
            mem_sign_mask  <= dec_mask;
            mem_memread    <= !req_is_store;
            mem_memwrite   <= req_is_store;
            is_load        <= !req_is_store;
            cnt            <= '0;
            state          <= ISSUE;
          end
        end
        ISSUE, WAIT_DONE: begin
          cnt <= cnt + 1'b1;
          if (state == WAIT_DONE && !mem_clk_stall) begin
            resp_rdata <= is_load ? mem_read_data : 32'h0;
            resp_err   <= ERR_OK;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (timeout) begin
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_err     <= ERR_TIMEOUT;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end else if (state == ISSUE && mem_clk_stall) begin
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            state        <= WAIT_DONE;
          end
        end
        RESP: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: randomized bench with a stalling memory model and a byte-array reference
module tb_mem_initiator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] mem_arr [64];
  logic [7:0] ref_mem [64];
  int  busy_len = 1;
  int  mcnt = 0;
  bit  stuck = 1'b0;
  logic [3:0] last_sm;
  int  last_wc;
  always #5 clk = ~clk;
  mem_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
  );
  // Memory without reset: latches a strobe when idle, stays busy busy_len cycles (forever while stuck)
  always @(posedge clk) begin
    if (!mem_clk_stall) begin
      if (mem_memread || mem_memwrite) begin
        mem_clk_stall <= 1'b1;
        mcnt <= busy_len;
        if (mem_memwrite)
          for (int i = 0; i < (mem_sign_mask[2] ? 4 : mem_sign_mask[1] ? 2 : 1); i++)
            mem_arr[6'(mem_addr[5:0] + 6'(i))] <= mem_write_data[8*i +: 8];
      end
    end else if (!stuck) begin
      if (mcnt <= 1) mem_clk_stall <= 1'b0;
      else mcnt <= mcnt - 1;
    end
  end
  logic [5:0]  ma;
  logic [31:0] mw;
  assign ma = mem_addr[5:0];
  assign mw = {mem_arr[ma + 6'd3], mem_arr[ma + 6'd2], mem_arr[ma + 6'd1], mem_arr[ma]};
  assign mem_read_data = mem_sign_mask[2] ? mw :
                         mem_sign_mask[1] ? {{16{mem_sign_mask[3] & mw[15]}}, mw[15:0]} :
                                            {{24{mem_sign_mask[3] & mw[7]}}, mw[7:0]};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    int n;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    w = 32'h0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = ref_mem[(int'(a[5:0]) + i) % 64];
    if (!f3[2] && n < 4 && w[8*n-1]) w = w | ~((32'h1 << (8*n)) - 32'h1);
    return w;
  endfunction
  task automatic poke(input int off, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem_arr[(off + i) % 64] = w[8*i +: 8];
      ref_mem[(off + i) % 64] = w[8*i +: 8];
    end
  endtask
  task automatic xfer(input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int blen, input bit to);
    bit ill, mis;
    logic [1:0] eerr;
    logic [31:0] erd;
    int elat, erc, ewc, lat, rc, wc, n;
    ill  = st ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 >= 3'd6);
    mis  = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
    eerr = ill ? 2'b10 : mis ? 2'b01 : to ? 2'b11 : 2'b00;
    elat = (ill || mis) ? 1 : to ? 17 : blen + 3;
    erd  = (eerr == 2'b00 && !st) ? ref_load(f3, a) : 32'h0;
    erc  = (ill || mis || st) ? 0 : 2;
    ewc  = (ill || mis || !st) ? 0 : 2;
    busy_len = blen;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("ready_wait", 32'(n < 100), 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; rc = 0; wc = 0;
    last_sm = mem_sign_mask;
    while (lat < 40) begin
      rc += int'(mem_memread);
      wc += int'(mem_memwrite);
      if (resp_valid) break;
      req_valid = 1'($urandom); req_is_store = 1'($urandom);
      req_funct3 = 3'($urandom); req_addr = $urandom;
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("latency", 32'(lat), 32'(elat));
    chk("resp_err", 32'(resp_err), 32'(eerr));
    chk("resp_rdata", resp_rdata, erd);
    chk("read_strobes", 32'(rc), 32'(erc));
    chk("write_strobes", 32'(wc), 32'(ewc));
    @(negedge clk);
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("rdata_hold", resp_rdata, erd);
    last_wc = wc;
    if (eerr == 2'b00 && st)
      for (int i = 0; i < (f3 == 3'd0 ? 1 : f3 == 3'd1 ? 2 : 4); i++)
        ref_mem[(int'(a[5:0]) + i) % 64] = wd[8*i +: 8];
  endtask
  initial begin
    int bad, seen, n;
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = 8'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    #1;
    chk("rst_memread", 32'(mem_memread), 32'd0);
    chk("rst_memwrite", 32'(mem_memwrite), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_write_data, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_sign_mask", 32'(mem_sign_mask), 32'h0);
    chk("rst_err", 32'(resp_err), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    poke(4, 32'hDEADBEEF);
    xfer(1'b0, 3'b010, 32'h0000_1004, 32'h0, 1, 1'b0);
    mem_arr[7] = 8'h80; ref_mem[7] = 8'h80;
    xfer(1'b0, 3'b000, 32'h0000_1007, 32'h0, 1, 1'b0);
    chk("lb_sign_mask", 32'(last_sm), 32'b1001);
    chk("lb_value", resp_rdata, 32'hFFFF_FF80);
    xfer(1'b0, 3'b100, 32'h0000_1007, 32'h0, 1, 1'b0);
    chk("lbu_sign_mask", 32'(last_sm), 32'b0001);
    chk("lbu_value", resp_rdata, 32'h0000_0080);
    poke(0, 32'hAABBCCDD);
    xfer(1'b1, 3'b001, 32'h0000_1002, 32'h0000_1234, 1, 1'b0);
    chk("sh_memwrite_cycles", 32'(last_wc), 32'd2);
    xfer(1'b0, 3'b010, 32'h0000_1000, 32'h0, 1, 1'b0);
    chk("sh_lw_value", resp_rdata, 32'h1234_CCDD);
    xfer(1'b0, 3'b010, 32'h0000_1006, 32'h0, 1, 1'b0);
    chk("misalign_err", 32'(resp_err), 32'b01);
    xfer(1'b0, 3'b011, 32'h0000_1004, 32'h0, 1, 1'b0);
    chk("funct3_err", 32'(resp_err), 32'b10);
    xfer(1'b1, 3'b101, 32'h0000_1003, 32'h0, 1, 1'b0);
    chk("funct3_over_misalign", 32'(resp_err), 32'b10);
    stuck = 1'b1;
    xfer(1'b0, 3'b010, 32'h0000_1008, 32'h0, 1, 1'b1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      bad += int'(req_ready);
      @(negedge clk);
    end
    chk("timeout_ready_gated", 32'(bad), 32'd0);
    stuck = 1'b0;
    poke(16, 32'h0BAD_F00D);
    xfer(1'b0, 3'b010, 32'h0000_1010, 32'h0, 1, 1'b0);
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    busy_len = 8;
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_1010;
    @(negedge clk);
    req_valid = 1'b0;
    chk("issue_memread", 32'(mem_memread), 32'd1);
    @(negedge clk); @(negedge clk);
    chk("wait_stall", 32'(mem_clk_stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_memread", 32'(mem_memread), 32'd0);
    chk("async_rst_memwrite", 32'(mem_memwrite), 32'd0);
    chk("async_rst_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0; seen = 0; n = 0;
    while (mem_clk_stall && n < 50) begin
      bad += int'(req_ready);
      seen += int'(resp_valid);
      @(negedge clk);
      n++;
    end
    chk("drain_bound", 32'(n < 50), 32'd1);
    chk("drain_ready_gated", 32'(bad), 32'd0);
    chk("rst_no_resp", 32'(seen + int'(resp_valid)), 32'd0);
    chk("ready_after_drain", 32'(req_ready), 32'd1);
    xfer(1'b0, 3'b010, 32'h0000_1010, 32'h0, 1, 1'b0);
    chk("post_rst_lw", resp_rdata, 32'h0BAD_F00D);
    for (int k = 0; k < 150; k++)
      xfer(1'($urandom), 3'($urandom), 32'h0000_1000 + 32'($urandom_range(0, 63)),
           $urandom, int'($urandom_range(1, 3)), 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- CPU-side initiator for the data-memory stall handshake.
- Accepts one load/store request at a time from the pipeline and maps RV32I funct3 to the memory's sign_mask encoding.
- Drives memread/memwrite, addr and write_data, and tracks clk_stall to know when the access completes.
- Returns the read word, or an error code for misaligned accesses, illegal funct3 values and handshake timeouts.
- Sits between the execute/memory pipeline stage and the data memory.

Parameters:
- TIMEOUT_CYCLES, 16: cycles allowed in ISSUE or WAIT_DONE before the access is aborted; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  pipeline request strobe
- req_ready  output  1  initiator can accept a request this cycle
- req_is_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I load/store funct3
- req_addr  input  32  byte address
- req_wdata  input  32  store data (rs2, unshifted)
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  load result, already extended by the memory; 0 for stores and errors
- resp_err  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
- mem_addr  output  32  memory address
- mem_write_data  output  32  memory write data
- mem_memwrite  output  1  memory write strobe
- mem_memread  output  1  memory read strobe
- mem_sign_mask  output  4  {sign, size mask}
- mem_read_data  input  32  memory read data
- mem_clk_stall  input  1  memory busy indicator

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - mem_memread, mem_memwrite, resp_valid = 0.
  - mem_addr, mem_write_data, resp_rdata = 0.
  - mem_sign_mask = 0, resp_err = 00.
- req_ready = (state==IDLE) && !mem_clk_stall.
  - The memory has no reset, so a transaction interrupted by rst_n must drain before the next accept.
- sign_mask mapping:
  - Loads: funct3 000 → 1001, 001 → 1011, 010 → 1111, 100 → 0001, 101 → 0011; 011, 110, 111 are illegal.
  - Stores: 000 → 0001, 001 → 0011, 010 → 0111; funct3 ≥ 011 is illegal.
- Misaligned: half-word access with addr[0]=1, or word access with addr[1:0]≠00.
  - Illegal funct3 takes priority over misaligned.
- IDLE: on accept (req_valid && req_ready):
  - Error case: no bus activity, go to RESP with the error code.
  - Otherwise register mem_addr, mem_write_data and mem_sign_mask, assert mem_memread or mem_memwrite, go to ISSUE, clear the timeout counter.
- ISSUE: hold all mem_* outputs. On the edge that samples mem_clk_stall=1 (memory has latched the request), drop both strobes and go to WAIT_DONE.
- WAIT_DONE:
  - Keep mem_addr, mem_write_data and mem_sign_mask stable; the memory uses them combinationally while stalled.
  - On the edge that samples mem_clk_stall=0, capture mem_read_data (loads) into resp_rdata and go to RESP.
- Strobe timing: strobes must be 0 when the memory returns to its idle state, otherwise it re-triggers. Dropping them in ISSUE guarantees this.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_err hold until the next RESP.
- Latency: accept edge E0 → memory latches at E1 → strobes drop at E2 → capture at E3 → resp_valid high in the cycle after E3.
  - Total 4 cycles for loads and stores.
  - Error responses take 1 cycle (resp_valid high the cycle after accept).
- Timeout:
  - The counter increments each cycle in ISSUE and WAIT_DONE.
  - At TIMEOUT_CYCLES: drop strobes, resp_err=11, resp_rdata=0, go to RESP.
  - After a timeout, req_ready stays gated by mem_clk_stall.
- req_valid while not ready: ignored, with no side effects.
- Reset mid-operation: strobes drop immediately (async) and no response is issued.

Decomposition:
- Package mem_if_pkg holds:
  - State encoding: IDLE, ISSUE, WAIT_DONE, RESP.
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - sign_mask constants.
  - resp_err codes.
- One combinational sub-module, mem_req_decode: inputs funct3, is_store, addr[1:0]; outputs sign_mask, illegal, misaligned.
- The FSM, timeout counter and registers live in mem_initiator.

Test Plan:
- LW at 0x00001004 with memory word 0xDEADBEEF → strobes drop at E2; resp_valid 4 cycles after accept; resp_rdata=0xDEADBEEF; resp_err=00.
- LB at 0x00001007, memory byte 0x80 → mem_sign_mask=1001; resp_rdata=0xFFFFFF80. LBU at the same address → 0001; resp_rdata=0x00000080.
- SH of 0x1234 to 0x00001002, then LW of the same word that held 0xAABBCCDD → resp_rdata=0x1234CCDD. mem_memwrite is high for exactly 2 cycles.
- LW at 0x00001006 → resp_err=01 after 1 cycle; mem_memread never asserted. Load funct3=011 → resp_err=10.
- Memory model holds mem_clk_stall=1 indefinitely, TIMEOUT_CYCLES=16 → resp_err=11 after 16 cycles; req_ready stays 0 until stall falls.
- rst_n pulsed low during WAIT_DONE → strobes drop asynchronously; no resp_valid; req_ready=1 only after mem_clk_stall=0. The next LW completes normally.
